prco_regfile: RTL

PRCO_REGFILE -- requirements
Module: prco_regfile

---
 rtl/prco_regfile_if.sv | 38 +++
 rtl/prco_regfile.sv | 119 +++++++++++
 2 files changed

// File: rtl/prco_regfile_if.sv
// Register-file access bundle: two read ports, one write port, lock and SP-adjust controls.
// Latency: none (wires only); timing is owned by the register file that uses it.
// Backpressure: none; i_ce is the only flow control and freezes the whole pipeline stage.
interface prco_regfile_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic              i_ce;
    logic [AW-1:0]     i_sela;
    logic [AW-1:0]     i_selb;
    logic [DATA_W-1:0] q_data;
    logic [DATA_W-1:0] q_datb;
    logic              q_hz_a;
    logic              q_hz_b;
    logic              i_we;
    logic [AW-1:0]     i_seld;
    logic [DATA_W-1:0] i_datd;
    logic              i_lock;
    logic [AW-1:0]     i_lsel;
    logic              i_sp_inc;
    logic              i_sp_dec;

    // Pipeline control side: drives selects/writes, consumes read data and hazards.
    modport master (
        output i_ce, i_sela, i_selb, i_we, i_seld, i_datd,
               i_lock, i_lsel, i_sp_inc, i_sp_dec,
        input  q_data, q_datb, q_hz_a, q_hz_b
    );

    // Register file side.
    modport slave (
        input  i_ce, i_sela, i_selb, i_we, i_seld, i_datd,
               i_lock, i_lsel, i_sp_inc, i_sp_dec,
        output q_data, q_datb, q_hz_a, q_hz_b
    );
endinterface

// File: rtl/prco_regfile.sv
// CPU register file with per-register busy (hazard) bits, SP inc/dec and optional write bypass.
// Latency: 1 cycle from select to q_data/q_datb/q_hz_*; writes visible same edge when BYPASS=1.
// Backpressure: none; i_ce low holds every register, busy bit and output.
module prco_regfile #(
    parameter int                DATA_W    = 16,
    parameter int                NUM_REGS  = 8,
    parameter int                SP_IDX    = 6,
    parameter logic [DATA_W-1:0] SP_INIT   = 'h00FF,
    parameter int                BP_IDX    = 7,
    parameter logic [DATA_W-1:0] BP_INIT   = 'h00FF,
    parameter int                BYPASS    = 1,
    parameter int                REG0_ZERO = 0
) (
    input logic           i_clk,
    input logic           i_reset,
    prco_regfile_if.slave bus
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // SP adjust only exists if SP is a real, non-hardwired register.
    localparam bit SP_LIVE = (SP_IDX < NUM_REGS) && !((REG0_ZERO != 0) && (SP_IDX == 0));

    logic [DATA_W-1:0]   regs     [NUM_REGS];
    logic [DATA_W-1:0]   regs_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [DATA_W-1:0]   rd_a;
    logic [DATA_W-1:0]   rd_b;
    logic                hz_a;
    logic                hz_b;

    // A select addresses real storage only if it is in range and not the hardwired zero.
    function automatic logic sel_live(input logic [AW-1:0] s);
        return (int'(s) < NUM_REGS) && !((REG0_ZERO != 0) && (s == '0));
    endfunction

    // Next register/busy state: SP adjust first, so a write to SP overrides it.
    always_comb begin
        regs_nxt = regs;
        busy_nxt = busy;
        if (SP_LIVE && (bus.i_sp_inc != bus.i_sp_dec)) begin
            if (bus.i_sp_inc) begin
                regs_nxt[SP_IDX] = regs[SP_IDX] + 1'b1;
            end else begin
                regs_nxt[SP_IDX] = regs[SP_IDX] - 1'b1;
            end
        end
        if (bus.i_we && sel_live(bus.i_seld)) begin
            regs_nxt[bus.i_seld] = bus.i_datd;
            busy_nxt[bus.i_seld] = 1'b0;
        end
        // Lock after write: lock+write on the same register leaves it busy.
        if (bus.i_lock && sel_live(bus.i_lsel)) begin
            busy_nxt[bus.i_lsel] = 1'b1;
        end
    end

    // Read muxes: post-update state with bypass, pre-update state without.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        hz_a = 1'b0;
        hz_b = 1'b0;
        if (sel_live(bus.i_sela)) begin
            if (BYPASS != 0) begin
                rd_a = regs_nxt[bus.i_sela];
                hz_a = busy_nxt[bus.i_sela];
            end else begin
                rd_a = regs[bus.i_sela];
                hz_a = busy[bus.i_sela];
            end
        end
        if (sel_live(bus.i_selb)) begin
            if (BYPASS != 0) begin
                rd_b = regs_nxt[bus.i_selb];
                hz_b = busy_nxt[bus.i_selb];
            end else begin
                rd_b = regs[bus.i_selb];
                hz_b = busy[bus.i_selb];
            end
        end
    end

    // Register and busy storage; reset restores SP/BP initial values and clears all locks.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if ((REG0_ZERO != 0) && (i == 0)) begin
                    regs[i] <= '0;
                end else if (i == SP_IDX) begin
                    regs[i] <= SP_INIT;
                end else if (i == BP_IDX) begin
                    regs[i] <= BP_INIT;
                end else begin
                    regs[i] <= '0;
                end
            end
            busy <= '0;
        end else if (bus.i_ce) begin
            regs <= regs_nxt;
            busy <= busy_nxt;
        end
    end

    // Registered read outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bus.q_data <= '0;
            bus.q_datb <= '0;
            bus.q_hz_a <= 1'b0;
            bus.q_hz_b <= 1'b0;
        end else if (bus.i_ce) begin
            bus.q_data <= rd_a;
            bus.q_datb <= rd_b;
            bus.q_hz_a <= hz_a;
            bus.q_hz_b <= hz_b;
        end
    end
endmodule
